// File: rtl/rmad_pkg.sv
// rtl/rmad_pkg.sv - shared encodings and stage-register types for rmad_pipe
package rmad_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    RS_ALU  = 2'b00,
    RS_MEM  = 2'b01,
    RS_PC4  = 2'b10,
    RS_ALU2 = 2'b11
  } result_src_e;

  // Control half of the E->M stage register; the data half is sized by the top.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memwrite;
    result_src_e resultsrc;
  } stage_ctrl_t;

  function automatic logic is_mem_result(input result_src_e rs);
    return rs == RS_MEM;
  endfunction

endpackage

// File: rtl/rmad_if.sv
// rtl/rmad_if.sv - issue, flag and write-back signals of rmad_pipe
interface rmad_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     valid_i;
  logic                     ready_o;
  logic [ADDRESS_WIDTH-1:0] A1;
  logic [ADDRESS_WIDTH-1:0] A2;
  logic [ADDRESS_WIDTH-1:0] A3;
  logic                     RegWrite;
  logic                     ALUSrc;
  logic                     MemWrite;
  logic [DATA_WIDTH-1:0]    ImmExt;
  logic [DATA_WIDTH-1:0]    PCPlus4;
  logic [1:0]               ResultSrc;
  logic [2:0]               ALUControl;
  logic                     Zero;
  logic                     wb_valid_o;
  logic [ADDRESS_WIDTH-1:0] wb_rd_o;
  logic [DATA_WIDTH-1:0]    wb_data_o;

  modport master (
    output valid_i, A1, A2, A3, RegWrite, ALUSrc, MemWrite,
           ImmExt, PCPlus4, ResultSrc, ALUControl,
    input  ready_o, Zero, wb_valid_o, wb_rd_o, wb_data_o
  );

  modport slave (
    input  valid_i, A1, A2, A3, RegWrite, ALUSrc, MemWrite,
           ImmExt, PCPlus4, ResultSrc, ALUControl,
    output ready_o, Zero, wb_valid_o, wb_rd_o, wb_data_o
  );
endinterface

// File: rtl/rmad_regfile.sv
// rtl/rmad_regfile.sv - 2-read/1-write register file, write-through reads, x0 hardwired
module rmad_regfile #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] ra1,
  input  logic [ADDRESS_WIDTH-1:0] ra2,
  output logic [DATA_WIDTH-1:0]    rd1,
  output logic [DATA_WIDTH-1:0]    rd2,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0]    wd
);
  localparam int NREGS = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // A same-cycle write is visible to the reader, so W never needs a bypass here.
  assign rd1 = (ra1 == '0) ? '0 : ((we && (wa == ra1)) ? wd : regs[ra1]);
  assign rd2 = (ra2 == '0) ? '0 : ((we && (wa == ra2)) ? wd : regs[ra2]);

endmodule

// File: rtl/rmad_pipe.sv
// rtl/rmad_pipe.sv - three-stage E/M/W execute pipe with forwarding, load-use stall and data memory
module rmad_pipe
  import rmad_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 5,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int FORWARD_EN     = 1
) (
  input logic   clk,
  input logic   rst,
  rmad_if.slave bus
);
  localparam int MEM_WORDS = 1 << MEM_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]    rf_rd1;
  logic [DATA_WIDTH-1:0]    rf_rd2;
  logic [DATA_WIDTH-1:0]    src_a;
  logic [DATA_WIDTH-1:0]    rd2_fwd;
  logic [DATA_WIDTH-1:0]    src_b;
  logic [DATA_WIDTH-1:0]    alu_y;
  logic                     ready_e;
  logic                     accept;

  stage_ctrl_t              m_ctrl;
  logic [ADDRESS_WIDTH-1:0] m_rd;
  logic [DATA_WIDTH-1:0]    m_alu;
  logic [DATA_WIDTH-1:0]    m_wdata;
  logic [DATA_WIDTH-1:0]    m_pc4;
  logic [DATA_WIDTH-1:0]    m_rdata;
  logic [DATA_WIDTH-1:0]    m_result;
  logic [MEM_ADDR_WIDTH-1:0] m_idx;
  logic                     m_wr;
  logic                     m_fwd;
  logic                     m_load;
  logic                     m_hit;
  logic                     mem_we;

  logic                     w_valid;
  logic [ADDRESS_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0]    w_data;
  logic                     w_hit;

  logic [DATA_WIDTH-1:0]    dmem [MEM_WORDS];

  rmad_regfile #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_regfile (
    .clk(clk),
    .rst(rst),
    .ra1(bus.A1),
    .ra2(bus.A2),
    .rd1(rf_rd1),
    .rd2(rf_rd2),
    .we (w_valid),
    .wa (w_rd),
    .wd (w_data)
  );

  // W only ever holds ops that really write a nonzero register.
  assign m_wr   = m_ctrl.valid && m_ctrl.regwrite && (m_rd != '0);
  assign m_fwd  = m_wr && !is_mem_result(m_ctrl.resultsrc);
  assign m_load = m_wr && is_mem_result(m_ctrl.resultsrc);
  assign m_hit  = (m_rd == bus.A1) || (m_rd == bus.A2);
  assign w_hit  = w_valid && ((w_rd == bus.A1) || (w_rd == bus.A2));

  always_comb begin
    ready_e = 1'b1;
    if (FORWARD_EN != 0) begin
      if (m_load && m_hit) ready_e = 1'b0;
    end else begin
      if ((m_wr && m_hit) || w_hit) ready_e = 1'b0;
    end
  end

  assign accept = bus.valid_i && ready_e;

  always_comb begin
    src_a   = rf_rd1;
    rd2_fwd = rf_rd2;
    if (FORWARD_EN != 0) begin
      if (m_fwd && (m_rd == bus.A1))        src_a = m_alu;
      else if (w_valid && (w_rd == bus.A1)) src_a = w_data;
      if (m_fwd && (m_rd == bus.A2))        rd2_fwd = m_alu;
      else if (w_valid && (w_rd == bus.A2)) rd2_fwd = w_data;
    end
  end

  assign src_b = bus.ALUSrc ? bus.ImmExt : rd2_fwd;

  always_comb begin
    alu_y = '0;
    case (bus.ALUControl)
      ALU_ADD: alu_y = src_a + src_b;
      ALU_SUB: alu_y = src_a - src_b;
      ALU_AND: alu_y = src_a & src_b;
      ALU_OR:  alu_y = src_a | src_b;
      ALU_SLT: alu_y = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_y = '0;
    endcase
  end

  // Word index drops the byte offset and any address bits above the memory size.
  assign m_idx   = m_alu[MEM_ADDR_WIDTH+1:2];
  assign m_rdata = dmem[m_idx];
  assign mem_we  = m_ctrl.valid && m_ctrl.memwrite && !rst;

  always_comb begin
    m_result = m_alu;
    case (m_ctrl.resultsrc)
      RS_MEM:  m_result = m_rdata;
      RS_PC4:  m_result = m_pc4;
      default: m_result = m_alu;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) dmem[m_idx] <= m_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ctrl  <= '0;
      m_rd    <= '0;
      m_alu   <= '0;
      m_wdata <= '0;
      m_pc4   <= '0;
      w_valid <= 1'b0;
      w_rd    <= '0;
      w_data  <= '0;
    end else begin
      m_ctrl.valid <= accept;
      if (accept) begin
        m_ctrl.regwrite  <= bus.RegWrite;
        m_ctrl.memwrite  <= bus.MemWrite;
        m_ctrl.resultsrc <= result_src_e'(bus.ResultSrc);
        m_rd             <= bus.A3;
        m_alu            <= alu_y;
        m_wdata          <= rd2_fwd;
        m_pc4            <= bus.PCPlus4;
      end
      w_valid <= m_wr;
      if (m_wr) begin
        w_rd   <= m_rd;
        w_data <= m_result;
      end
    end
  end

  assign bus.ready_o    = ready_e;
  assign bus.Zero       = (alu_y == '0);
  assign bus.wb_valid_o = w_valid;
  assign bus.wb_rd_o    = w_rd;
  assign bus.wb_data_o  = w_data;

endmodule

// File: tb/tb_rmad_pipe.sv
// tb/tb_rmad_pipe.sv - directed vector bench for rmad_pipe, forwarding and non-forwarding builds
module tb_rmad_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rmad_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) if0 ();
  rmad_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) if1 ();

  rmad_pipe #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .MEM_ADDR_WIDTH(8), .FORWARD_EN(1)) u_fwd (
    .clk(clk), .rst(rst), .bus(if0)
  );
  rmad_pipe #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .MEM_ADDR_WIDTH(8), .FORWARD_EN(0)) u_nofwd (
    .clk(clk), .rst(rst), .bus(if1)
  );

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND = 3'b010, OR = 3'b011, SLT = 3'b101, BAD = 3'b111;
  localparam logic [1:0] R_ALU = 2'b00, R_MEM = 2'b01, R_PC = 2'b10, R_ALU2 = 2'b11;

  typedef struct {
    logic [4:0]  a1, a2, a3;
    logic        rw, src, mw;
    logic [31:0] imm;
    logic [1:0]  rs;
    logic [2:0]  alu;
    logic        exp_zero;
    logic        exp_wb;
    logic [31:0] exp_data;
    int          exp_stalls;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } wb_t;

  vec_t vecs[26];
  wb_t  expq[$];
  wb_t  q1[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t op(input logic [4:0] a1, a2, a3, input logic rw, src, mw,
                              input logic [31:0] imm, input logic [1:0] rs, input logic [2:0] alu,
                              input logic ez, ewb, input logic [31:0] ed, input int est);
    vec_t v;
    v.a1 = a1; v.a2 = a2; v.a3 = a3; v.rw = rw; v.src = src; v.mw = mw;
    v.imm = imm; v.rs = rs; v.alu = alu;
    v.exp_zero = ez; v.exp_wb = ewb; v.exp_data = ed; v.exp_stalls = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit nf, input vec_t v, input logic vld);
    if (!nf) begin
      if0.A1 = v.a1; if0.A2 = v.a2; if0.A3 = v.a3;
      if0.RegWrite = v.rw; if0.ALUSrc = v.src; if0.MemWrite = v.mw;
      if0.ImmExt = v.imm; if0.PCPlus4 = 32'h104; if0.ResultSrc = v.rs;
      if0.ALUControl = v.alu; if0.valid_i = vld;
    end else begin
      if1.A1 = v.a1; if1.A2 = v.a2; if1.A3 = v.a3;
      if1.RegWrite = v.rw; if1.ALUSrc = v.src; if1.MemWrite = v.mw;
      if1.ImmExt = v.imm; if1.PCPlus4 = 32'h104; if1.ResultSrc = v.rs;
      if1.ALUControl = v.alu; if1.valid_i = vld;
    end
  endtask

  // Presents one op, counts cycles with ready_o low, then lets it be accepted.
  task automatic issue(input bit nf, input int idx, input vec_t v);
    int   st = 0;
    logic rdy;
    @(negedge clk);
    drive(nf, v, 1'b1);
    #1;
    rdy = nf ? if1.ready_o : if0.ready_o;
    while (!rdy && st < 16) begin
      st++;
      @(negedge clk);
      #1;
      rdy = nf ? if1.ready_o : if0.ready_o;
    end
    chk($sformatf("op%0d_ready", idx), rdy, 1'b1);
    chk($sformatf("op%0d_zero", idx), nf ? if1.Zero : if0.Zero, v.exp_zero);
    chk($sformatf("op%0d_stalls", idx), st, v.exp_stalls);
    if (v.exp_wb && !nf) expq.push_back({v.a3, v.exp_data});
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && if0.wb_valid_o) begin
      n_vec++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write-back", if0.wb_rd_o, if0.wb_data_o);
      end else begin
        wb_t e;
        e = expq.pop_front();
        if (if0.wb_rd_o !== e.rd || if0.wb_data_o !== e.d) begin
          n_fail++;
          $display("FAIL wb_event: got rd=%0d data=%h, required rd=%0d data=%h",
                   if0.wb_rd_o, if0.wb_data_o, e.rd, e.d);
        end
      end
    end
    if (!rst && if1.wb_valid_o) q1.push_back({if1.wb_rd_o, if1.wb_data_o});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    vec_t idle_v;
    vec_t junk;
    wb_t  e;
    idle_v = op(0, 0, 0, 0, 0, 0, 0, R_ALU, ADD, 0, 0, 0, 0);
    drive(0, idle_v, 1'b0);
    drive(1, idle_v, 1'b0);

    //           a1  a2  a3  rw src mw imm            rs      alu  z  wb data           stall
    vecs[0]  = op(0,  0,  1,  1, 1, 0, 32'd5,         R_ALU,  ADD, 0, 1, 32'd5,         0);
    vecs[1]  = op(1,  1,  2,  1, 0, 0, 32'd0,         R_ALU,  ADD, 0, 1, 32'd10,        0);
    vecs[2]  = op(0,  0,  0,  1, 1, 0, 32'd9,         R_ALU,  ADD, 0, 0, 32'd0,         0);
    vecs[3]  = op(0,  0,  5,  1, 0, 0, 32'd0,         R_ALU,  ADD, 1, 1, 32'd0,         0);
    vecs[4]  = op(0,  0,  6,  1, 1, 0, 32'd7,         R_ALU,  ADD, 0, 1, 32'd7,         0);
    vecs[5]  = op(0,  0,  7,  1, 1, 0, 32'h10,        R_ALU,  ADD, 0, 1, 32'h10,        0);
    vecs[6]  = op(7,  6,  0,  0, 1, 1, 32'd0,         R_ALU,  ADD, 0, 0, 32'd0,         0);
    vecs[7]  = op(0,  0,  3,  1, 1, 0, 32'h10,        R_MEM,  ADD, 0, 1, 32'd7,         0);
    vecs[8]  = op(3,  3,  4,  1, 0, 0, 32'd0,         R_ALU,  ADD, 0, 1, 32'd14,        1);
    vecs[9]  = op(0,  0,  8,  1, 1, 0, 32'd3,         R_ALU,  ADD, 0, 1, 32'd3,         0);
    vecs[10] = op(0,  0,  9,  1, 1, 0, 32'd3,         R_ALU,  ADD, 0, 1, 32'd3,         0);
    vecs[11] = op(8,  9, 10,  1, 0, 0, 32'd0,         R_ALU,  SUB, 1, 1, 32'd0,         0);
    vecs[12] = op(0,  0, 11,  1, 1, 0, 32'hFFFF_FFFF, R_ALU,  ADD, 0, 1, 32'hFFFF_FFFF, 0);
    vecs[13] = op(0,  0, 12,  1, 1, 0, 32'd1,         R_ALU,  ADD, 0, 1, 32'd1,         0);
    vecs[14] = op(11, 12, 13, 1, 0, 0, 32'd0,         R_ALU,  SLT, 0, 1, 32'd1,         0);
    vecs[15] = op(0,  0, 14,  1, 1, 0, 32'hA5,        R_ALU,  ADD, 0, 1, 32'hA5,        0);
    vecs[16] = op(0, 14,  0,  0, 1, 1, 32'h400,       R_ALU,  ADD, 0, 0, 32'd0,         0);
    vecs[17] = op(0,  0, 15,  1, 1, 0, 32'd0,         R_MEM,  ADD, 1, 1, 32'hA5,        0);
    vecs[18] = op(15, 14, 16, 1, 0, 0, 32'd0,         R_ALU,  AND, 0, 1, 32'hA5,        1);
    vecs[19] = op(12, 12, 18, 1, 0, 0, 32'd0,         R_ALU,  BAD, 1, 1, 32'd0,         0);
    vecs[20] = op(0,  0, 19,  1, 1, 0, 32'd0,         R_PC,   ADD, 1, 1, 32'h104,       0);
    vecs[21] = op(0,  0, 20,  0, 1, 0, 32'd1,         R_ALU,  ADD, 0, 0, 32'd0,         0);
    vecs[22] = op(0,  0, 21,  1, 1, 0, 32'h22,        R_ALU2, ADD, 0, 1, 32'h22,        0);
    vecs[23] = op(13, 11, 22, 1, 0, 0, 32'd0,         R_ALU,  OR,  0, 1, 32'hFFFF_FFFF, 0);
    vecs[24] = op(0,  0, 23,  1, 1, 0, 32'h10,        R_MEM,  ADD, 0, 1, 32'd7,         0);
    vecs[25] = op(25, 0, 24,  1, 0, 0, 32'd0,         R_ALU,  ADD, 1, 1, 32'd0,         0);

    @(negedge clk);
    chk("rst_ready", if0.ready_o, 1'b1);
    chk("rst_wb_valid", if0.wb_valid_o, 1'b0);
    chk("rst_wb_rd", if0.wb_rd_o, 5'd0);
    chk("rst_wb_data", if0.wb_data_o, 32'd0);
    chk("rst_ready_nofwd", if1.ready_o, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) issue(0, i, vecs[i]);

    // Bubbles carrying write/store controls must leave no trace.
    junk = op(0, 14, 25, 1, 1, 1, 32'h10, R_ALU, ADD, 0, 0, 0, 0);
    repeat (2) begin
      @(negedge clk);
      drive(0, junk, 1'b0);
    end
    for (int i = 24; i < 26; i++) issue(0, i, vecs[i]);

    issue(0, 100, op(0, 0, 22, 1, 1, 0, 32'h33, R_ALU, ADD, 0, 1, 32'h33, 0));
    issue(0, 101, op(0, 0, 26, 1, 1, 0, 32'h44, R_ALU, ADD, 0, 0, 32'd0, 0));
    @(negedge clk);
    drive(0, op(0, 0, 29, 1, 1, 0, 32'h55, R_ALU, ADD, 0, 0, 0, 0), 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", if0.ready_o, 1'b1);
    chk("midrst_wb_valid", if0.wb_valid_o, 1'b0);
    chk("midrst_wb_rd", if0.wb_rd_o, 5'd0);
    chk("midrst_wb_data", if0.wb_data_o, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ready_edge", if0.ready_o, 1'b1);
    if0.valid_i = 1'b0;
    rst = 1'b0;

    issue(0, 102, op(1,  2, 27, 1, 0, 0, 32'd0, R_ALU, ADD, 1, 1, 32'd0, 0));
    issue(0, 103, op(22, 26, 28, 1, 0, 0, 32'd0, R_ALU, ADD, 1, 1, 32'd0, 0));
    @(negedge clk);
    if0.valid_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("wb_drain", expq.size(), 0);

    issue(1, 200, op(0, 0, 1, 1, 1, 0, 32'd5, R_ALU, ADD, 0, 1, 32'd5, 0));
    issue(1, 201, op(1, 1, 2, 1, 0, 0, 32'd0, R_ALU, ADD, 0, 1, 32'd10, 2));
    @(negedge clk);
    if1.valid_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("nofwd_events", q1.size(), 2);
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("nofwd_wb0_rd", e.rd, 5'd1);
      chk("nofwd_wb0_data", e.d, 32'd5);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("nofwd_wb1_rd", e.rd, 5'd2);
      chk("nofwd_wb1_data", e.d, 32'd10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
